// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle main control FSM and the ALU control decoder.
// Build option: MC_CTRL_JUMP_EN adds the j instruction (opcode 000010).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RCOMP  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // Opcodes this build can execute; anything else is flagged in DECODE.
  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) || (op == OP_BEQ);
`ifdef MC_CTRL_JUMP_EN
    ok = ok || (op == OP_J);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational control-output decode from the FSM state (plus mem_ready/opcode where they matter).
// Build option: MC_CTRL_JUMP_EN enables the JUMP state decode; otherwise PCSource never reaches 10.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Moore decode per state; every field not set below stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_BOFF;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = ~op_legal(opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RCOMP: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
`ifdef MC_CTRL_JUMP_EN
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle main control FSM for the MIPS-subset datapath: state register, next-state logic,
// retired-instruction counter. Output decode lives in mc_ctrl_outdec.
// Build option: MC_CTRL_JUMP_EN adds the j instruction via the JUMP state.
//
//  state  | meaning
//  FETCH  | read instruction at PC, PC+4 -> PC when memory completes
//  DECODE | register read, branch target computed into ALUOut
//  MEMADR | effective address for lw/sw
//  MEMRD  | data read for lw, waits on mem_ready
//  MEMWB  | MDR written to rt
//  MEMWR  | data write for sw, waits on mem_ready
//  EXEC   | R-type ALU operation
//  RCOMP  | ALU result written to rd
//  BRANCH | beq compare and conditional PC load
//  JUMP   | j target loaded into PC
module mc_main_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUop,
  output logic [1:0]       PCSource,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired_cnt
);

  state_t state;
  ctrl_t  ctrl;
  ctrl_t  ctrl_q;

  mc_ctrl_outdec u_outdec (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // While reset is asserted every output is held low, even before the reset edge arrives.
  assign ctrl_q = rst_n ? ctrl : '0;

  assign PCWrite     = ctrl_q.pc_write;
  assign PCWriteCond = ctrl_q.pc_write_cond;
  assign IorD        = ctrl_q.iord;
  assign MemRead     = ctrl_q.mem_read;
  assign MemWrite    = ctrl_q.mem_write;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign IRWrite     = ctrl_q.ir_write;
  assign RegDst      = ctrl_q.reg_dst;
  assign RegWrite    = ctrl_q.reg_write;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign ALUop       = ctrl_q.alu_op;
  assign PCSource    = ctrl_q.pc_source;
  assign instr_done  = ctrl_q.instr_done;
  assign illegal_op  = ctrl_q.illegal_op;

  // State register and next-state logic; unreachable encodings recover to FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXEC;
            OP_BEQ:       state <= S_BRANCH;
`ifdef MC_CTRL_JUMP_EN
            OP_J:         state <= S_JUMP;
`endif
            default:      state <= S_FETCH;
          endcase
        end
        // IR is stable from DECODE on, so opcode still distinguishes lw from sw here.
        S_MEMADR: state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_EXEC:   state <= S_RCOMP;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Retired-instruction counter, bumped on the edge closing each instr_done cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (ctrl.instr_done) begin
      retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Table-driven bench for mc_main_ctrl (instantiated with a 4-bit counter to exercise wrap).
// Expectations follow the MC_CTRL_JUMP_EN setting of the build.
module tb_mc_main_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, ALUop, PCSource;
  logic [3:0] retired_cnt;
  logic [17:0] act;

  always #5 clk = ~clk;

  mc_main_ctrl #(.CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUop       (ALUop),
    .PCSource    (PCSource),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .retired_cnt (retired_cnt)
  );

  // Field order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite RegDst RegWrite
  //              ALUSrcA ALUSrcB[2] ALUop[2] PCSource[2] instr_done illegal_op
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource, instr_done, illegal_op};

  localparam logic [17:0] C_ZERO    = 18'b0;
  localparam logic [17:0] C_FETCH_R = 18'b1_0_0_1_0_0_1_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_FETCH_W = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] C_DEC_ILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [17:0] C_MEMADR  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_MEMRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MEMWB   = 18'b0_0_0_0_0_1_0_0_1_0_00_00_00_1_0;
  localparam logic [17:0] C_MEMWR_W = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MEMWR_R = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] C_EXEC    = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] C_RCOMP   = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] C_BRANCH  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] C_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

  typedef struct packed {
    logic        rst_n;
    logic [5:0]  op;
    logic        rdy;
    logic [17:0] ctl;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(input logic r, input logic [5:0] op, input logic rdy,
                              input logic [17:0] ctl, input logic [3:0] cnt);
    vec_t v;
    v.rst_n = r; v.op = op; v.rdy = rdy; v.ctl = ctl; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  // Apply one cycle of inputs, check outputs before the next rising edge.
  task automatic run_row(input string tag, input int idx, input vec_t v);
    @(negedge clk);
    rst_n     = v.rst_n;
    opcode    = v.op;
    mem_ready = v.rdy;
    #1;
    n_checks++;
    if (act !== v.ctl) begin
      n_fail++;
      $display("FAIL %s ctl row %0d: got %b expected %b", tag, idx, act, v.ctl);
    end
    n_checks++;
    if (retired_cnt !== v.cnt) begin
      n_fail++;
      $display("FAIL %s retired_cnt row %0d: got %0d expected %0d", tag, idx, retired_cnt, v.cnt);
    end
  endtask

  task automatic run_all(input string tag);
    for (int i = 0; i < vecs.size(); i++) run_row(tag, i, vecs[i]);
    vecs.delete();
  endtask

  initial begin
    int jc;
`ifdef MC_CTRL_JUMP_EN
    jc = 1;
`else
    jc = 0;
`endif
    rst_n = 1'b0; opcode = 6'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Main table: reset, lw, R-type, beq, sw with wait states, illegal, j.
    add(0, RT,  1, C_ZERO,    0);
    add(1, LW,  1, C_FETCH_R, 0);
    add(1, LW,  1, C_DECODE,  0);
    add(1, LW,  1, C_MEMADR,  0);
    add(1, LW,  1, C_MEMRD,   0);
    add(1, LW,  1, C_MEMWB,   0);
    add(1, RT,  1, C_FETCH_R, 1);
    add(1, RT,  1, C_DECODE,  1);
    add(1, RT,  1, C_EXEC,    1);
    add(1, RT,  1, C_RCOMP,   1);
    add(1, BEQ, 1, C_FETCH_R, 2);
    add(1, BEQ, 1, C_DECODE,  2);
    add(1, BEQ, 1, C_BRANCH,  2);
    add(1, SW,  0, C_FETCH_W, 3);
    add(1, SW,  1, C_FETCH_R, 3);
    add(1, SW,  1, C_DECODE,  3);
    add(1, SW,  0, C_MEMADR,  3);
    add(1, SW,  0, C_MEMWR_W, 3);
    add(1, SW,  0, C_MEMWR_W, 3);
    add(1, SW,  0, C_MEMWR_W, 3);
    add(1, SW,  1, C_MEMWR_R, 3);
    add(1, ADDI, 1, C_FETCH_R, 4);
    add(1, ADDI, 1, C_DEC_ILL, 4);
    add(1, JMP, 1, C_FETCH_R, 4);
    if (jc == 1) begin
      add(1, JMP, 1, C_DECODE, 4);
      add(1, JMP, 1, C_JUMP,   4);
    end else begin
      add(1, JMP, 1, C_DEC_ILL, 4);
    end
    add(1, RT, 1, C_FETCH_R, 4'(4 + jc));
    add(1, RT, 1, C_DECODE,  4'(4 + jc));
    add(1, RT, 1, C_EXEC,    4'(4 + jc));
    add(1, RT, 1, C_RCOMP,   4'(4 + jc));
    add(1, LW, 1, C_FETCH_R, 4'(5 + jc));
    run_all("main");

    // Reset in MEMRD: outputs drop at once, FETCH and zero count after the edge.
    add(1, LW, 1, C_DECODE,  4'(5 + jc));
    add(1, LW, 1, C_MEMADR,  4'(5 + jc));
    add(1, LW, 0, C_MEMRD,   4'(5 + jc));
    add(1, LW, 0, C_MEMRD,   4'(5 + jc));
    add(0, LW, 1, C_ZERO,    4'(5 + jc));
    add(0, LW, 1, C_ZERO,    0);
    add(1, LW, 1, C_FETCH_R, 0);
    add(1, LW, 1, C_DECODE,  0);
    add(0, LW, 1, C_ZERO,    0);
    run_all("rst");

    // 16 R-type instructions wrap the 4-bit counter back to 0.
    for (int i = 0; i < 16; i++) begin
      add(1, RT, 1, C_FETCH_R, 4'(i));
      add(1, RT, 1, C_DECODE,  4'(i));
      add(1, RT, 1, C_EXEC,    4'(i));
      add(1, RT, 1, C_RCOMP,   4'(i));
    end
    add(1, RT, 1, C_FETCH_R, 0);
    run_all("wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
